// File: rtl/task_sched_pkg.sv
// Shared types for the ready-set scheduler and next_task_handler.
// Build option: define TASK_SCHED_STATS_EN to get a live switch_count counter.
package task_sched_pkg;

  localparam int DEF_NUM_TASKS  = 16;
  localparam int DEF_PRIO_WIDTH = 4;
  localparam int DEF_ID_WIDTH   = $clog2(DEF_NUM_TASKS);

  typedef logic [DEF_ID_WIDTH-1:0]   task_id_t;
  typedef logic [DEF_PRIO_WIDTH-1:0] task_prio_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_OFFER = 2'd2
  } sched_state_t;

endpackage

// File: rtl/task_prio_table.sv
// Per-task priority register file: one write port, two combinational read
// ports (scan index and running task).
module task_prio_table
  import task_sched_pkg::*;
#(
  parameter  int NUM_TASKS  = DEF_NUM_TASKS,
  parameter  int PRIO_WIDTH = DEF_PRIO_WIDTH,
  localparam int ID_WIDTH   = $clog2(NUM_TASKS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ID_WIDTH-1:0]   wr_id,
  input  logic [PRIO_WIDTH-1:0] wr_prio,
  input  logic [ID_WIDTH-1:0]   rd0_id,
  output logic [PRIO_WIDTH-1:0] rd0_prio,
  input  logic [ID_WIDTH-1:0]   rd1_id,
  output logic [PRIO_WIDTH-1:0] rd1_prio
);

  logic [PRIO_WIDTH-1:0] prio [NUM_TASKS];

  // Table write; IDs beyond NUM_TASKS-1 are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_TASKS; i++) prio[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_TASKS; i++)
        if (we && wr_id == ID_WIDTH'(i)) prio[i] <= wr_prio;
    end
  end

  // Two independent read ports; out-of-range IDs read as priority 0
  always_comb begin
    rd0_prio = '0;
    rd1_prio = '0;
    for (int unsigned i = 0; i < NUM_TASKS; i++) begin
      if (rd0_id == ID_WIDTH'(i)) rd0_prio = prio[i];
      if (rd1_id == ID_WIDTH'(i)) rd1_prio = prio[i];
    end
  end

endmodule

// File: rtl/task_ready_scheduler.sv
// Ready-set scheduler: serial scan for the highest-priority ready task and
// preemption offer to next_task_handler over valid/ready.
// Build option: TASK_SCHED_STATS_EN enables the 32-bit switch_count counter;
// without it switch_count is tied to zero.
module task_ready_scheduler
  import task_sched_pkg::*;
#(
  parameter  int NUM_TASKS  = DEF_NUM_TASKS,
  parameter  int PRIO_WIDTH = DEF_PRIO_WIDTH,
  localparam int ID_WIDTH   = $clog2(NUM_TASKS)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cfg_we,
  input  logic [ID_WIDTH-1:0]   cfg_task_id,
  input  logic [PRIO_WIDTH-1:0] cfg_prio,
  input  logic                  activate_valid,
  input  logic [ID_WIDTH-1:0]   activate_task_id,
  input  logic                  suspend_valid,
  input  logic [ID_WIDTH-1:0]   suspend_task_id,
  output logic                  next_valid,
  output logic [ID_WIDTH-1:0]   next_task_id,
  input  logic                  next_ready,
  output logic                  cur_valid,
  output logic [ID_WIDTH-1:0]   cur_task_id,
  output logic                  idle,
  output logic [31:0]           switch_count
);

  sched_state_t          state;
  logic [NUM_TASKS-1:0]  ready, ready_nxt;
  logic                  dirty, any_event, handshake;
  logic [ID_WIDTH-1:0]   scan_idx, best_id, cand_id;
  logic [PRIO_WIDTH-1:0] best_prio, cand_prio, scan_prio, cur_prio;
  logic                  best_found, cand_found, scan_ready, take, preempt;

  task_prio_table #(.NUM_TASKS(NUM_TASKS), .PRIO_WIDTH(PRIO_WIDTH)) u_prio (
    .clk(ACLK), .rst(ARESET),
    .we(cfg_we), .wr_id(cfg_task_id), .wr_prio(cfg_prio),
    .rd0_id(scan_idx), .rd0_prio(scan_prio),
    .rd1_id(cur_task_id), .rd1_prio(cur_prio)
  );

  assign any_event = cfg_we | activate_valid | suspend_valid;
  assign handshake = next_valid & next_ready;

  // Next ready set: activate first, then suspend so suspend wins on the same ID
  always_comb begin
    ready_nxt = ready;
    for (int unsigned i = 0; i < NUM_TASKS; i++)
      if (activate_valid && activate_task_id == ID_WIDTH'(i)) ready_nxt[i] = 1'b1;
    for (int unsigned i = 0; i < NUM_TASKS; i++)
      if (suspend_valid && suspend_task_id == ID_WIDTH'(i)) ready_nxt[i] = 1'b0;
  end

  // Best-so-far including the slot under the scan index; strict > keeps lowest ID on ties
  always_comb begin
    scan_ready = 1'b0;
    for (int unsigned i = 0; i < NUM_TASKS; i++)
      if (scan_idx == ID_WIDTH'(i)) scan_ready = ready[i];
    take       = scan_ready && (!best_found || scan_prio > best_prio);
    cand_found = best_found | take;
    cand_id    = take ? scan_idx  : best_id;
    cand_prio  = take ? scan_prio : best_prio;
    preempt    = cand_found &&
                 (!cur_valid || (cand_id != cur_task_id && cand_prio > cur_prio));
  end

  // Scheduler FSM, ready set, running-task record and registered outputs
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state        <= ST_IDLE;
      ready        <= '0;
      dirty        <= 1'b0;
      scan_idx     <= '0;
      best_id      <= '0;
      best_prio    <= '0;
      best_found   <= 1'b0;
      next_valid   <= 1'b0;
      next_task_id <= '0;
      cur_valid    <= 1'b0;
      cur_task_id  <= '0;
      idle         <= 1'b1;
    end else begin
      ready <= ready_nxt;
      idle  <= ~|ready;

      if (handshake) begin
        cur_valid   <= 1'b1;
        cur_task_id <= next_task_id;
      end else if (suspend_valid && cur_valid && suspend_task_id == cur_task_id) begin
        cur_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (dirty) begin
            dirty      <= 1'b0;
            scan_idx   <= '0;
            best_id    <= '0;
            best_prio  <= '0;
            best_found <= 1'b0;
            state      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          best_id    <= cand_id;
          best_prio  <= cand_prio;
          best_found <= cand_found;
          if (scan_idx == ID_WIDTH'(NUM_TASKS - 1)) begin
            if (preempt) begin
              next_valid   <= 1'b1;
              next_task_id <= cand_id;
              state        <= ST_OFFER;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            scan_idx <= scan_idx + ID_WIDTH'(1);
          end
        end
        ST_OFFER: begin
          if (next_ready) begin
            next_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Placed after the case so a same-cycle event overrides the clear in IDLE
      if (any_event) dirty <= 1'b1;
    end
  end

`ifdef TASK_SCHED_STATS_EN
  // Accepted-handshake counter, wraps naturally at 32 bits
  always_ff @(posedge ACLK) begin
    if (ARESET)         switch_count <= '0;
    else if (handshake) switch_count <= switch_count + 32'd1;
  end
`else
  assign switch_count = '0;
`endif

endmodule

// File: tb/tb_task_ready_scheduler.sv
// Self-checking bench for task_ready_scheduler: behavioural ready-set model,
// expected offers queued at stimulus time and checked by an output monitor.
module tb_task_ready_scheduler;

  localparam int NT = 16;
  localparam int PW = 4;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_task_id = '0;
  logic [3:0]  cfg_prio = '0;
  logic        activate_valid = 1'b0;
  logic [3:0]  activate_task_id = '0;
  logic        suspend_valid = 1'b0;
  logic [3:0]  suspend_task_id = '0;
  logic        next_ready = 1'b0;
  logic        next_valid;
  logic [3:0]  next_task_id;
  logic        cur_valid;
  logic [3:0]  cur_task_id;
  logic        idle;
  logic [31:0] switch_count;

  task_ready_scheduler #(.NUM_TASKS(NT), .PRIO_WIDTH(PW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cfg_we(cfg_we), .cfg_task_id(cfg_task_id), .cfg_prio(cfg_prio),
    .activate_valid(activate_valid), .activate_task_id(activate_task_id),
    .suspend_valid(suspend_valid), .suspend_task_id(suspend_task_id),
    .next_valid(next_valid), .next_task_id(next_task_id), .next_ready(next_ready),
    .cur_valid(cur_valid), .cur_task_id(cur_task_id),
    .idle(idle), .switch_count(switch_count)
  );

  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit          m_ready [NT];
  int          m_prio  [NT];
  bit          m_cur_valid;
  int          m_cur;
  int unsigned m_count;
  int          sb_q [$];

  // Monitor state
  bit          prev_hold = 1'b0;
  logic [3:0]  prev_id = '0;
  int          exp_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_sw();
`ifdef TASK_SCHED_STATS_EN
    return m_count;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic model_idle();
    for (int i = 0; i < NT; i++) if (m_ready[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NT; i++) begin
      m_ready[i] = 1'b0;
      m_prio[i]  = 0;
    end
    m_cur_valid = 1'b0;
    m_cur       = 0;
    m_count     = 0;
    sb_q.delete();
  endtask

  task automatic check_reset();
    chk("rst_next_valid", next_valid, 0);
    chk("rst_next_id", next_task_id, 0);
    chk("rst_cur_valid", cur_valid, 0);
    chk("rst_cur_id", cur_task_id, 0);
    chk("rst_idle", idle, 1);
    chk("rst_switch_count", switch_count, 0);
  endtask

  task automatic reset_dut();
    next_ready = 1'b0;
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    model_clear();
    check_reset();
  endtask

  // One cycle of events; the model applies them with suspend after activate
  task automatic drive(input bit we, input int wid, input int wp,
                       input bit av, input int aid, input bit sv, input int sid);
    cfg_we = we; cfg_task_id = 4'(wid); cfg_prio = 4'(wp);
    activate_valid = av; activate_task_id = 4'(aid);
    suspend_valid = sv; suspend_task_id = 4'(sid);
    tick();
    cfg_we = 1'b0; activate_valid = 1'b0; suspend_valid = 1'b0;
    if (we) m_prio[wid] = wp;
    if (av) m_ready[aid] = 1'b1;
    if (sv) begin
      m_ready[sid] = 1'b0;
      if (m_cur_valid && m_cur == sid) m_cur_valid = 1'b0;
    end
  endtask

  // Highest priority among ready tasks, lowest ID among equals; offer if it preempts
  task automatic decide();
    int maxp = -1;
    int pick = -1;
    for (int i = 0; i < NT; i++) if (m_ready[i] && m_prio[i] > maxp) maxp = m_prio[i];
    if (maxp < 0) return;
    for (int i = NT - 1; i >= 0; i--) if (m_ready[i] && m_prio[i] == maxp) pick = i;
    if (!m_cur_valid || (pick != m_cur && maxp > m_prio[m_cur])) sb_q.push_back(pick);
  endtask

  task automatic settle();
    int budget = 0;
    repeat (NT + 6) begin
      next_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    while (sb_q.size() != 0 && budget < 300) begin
      next_ready = ($urandom_range(0, 2) != 0);
      tick();
      budget++;
    end
    next_ready = 1'b0;
    repeat (3) tick();
    chk("sb_drain", sb_q.size(), 0);
    chk("quiet_next_valid", next_valid, 0);
    chk("idle", idle, model_idle());
    chk("cur_valid", cur_valid, m_cur_valid);
    if (m_cur_valid) chk("cur_id", cur_task_id, m_cur);
    chk("switch_count", switch_count, exp_sw());
  endtask

  task automatic step(input bit we, input int wid, input int wp,
                      input bit av, input int aid, input bit sv, input int sid);
    drive(we, wid, wp, av, aid, sv, sid);
    decide();
    settle();
  endtask

  // Output monitor: pops the expected offer on every accepted handshake
  initial begin
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("offer_hold_valid", next_valid, 1);
          chk("offer_hold_id", next_task_id, prev_id);
        end
        if (next_valid && next_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_offer: got id %0d expected no offer at %0t", next_task_id, $time);
          end else begin
            exp_id = sb_q.pop_front();
            chk("offer_id", next_task_id, exp_id);
            m_cur       = exp_id;
            m_cur_valid = 1'b1;
            m_count++;
          end
        end
        prev_hold = next_valid && !next_ready;
        prev_id   = next_task_id;
      end
    end
  end

  initial begin
    int k;
    int id_a, id_s;
    model_clear();
    tick();
    reset_dut();

    // Single ready task at default priority: latency and first switch
    drive(0, 0, 0, 1, 3, 0, 0);
    decide();
    k = 1;
    while (!next_valid && k < 60) begin
      tick();
      k++;
    end
    chk("latency", k, NT + 2);
    chk("first_offer_id", next_task_id, 3);
    settle();

    // Higher priority preempts; equal priority does not
    step(1, 3, 2, 0, 0, 0, 0);
    step(1, 5, 7, 1, 5, 0, 0);
    step(1, 9, 7, 1, 9, 0, 0);

    // Equal priorities with nothing running: lowest ID wins
    reset_dut();
    step(1, 2, 4, 0, 0, 0, 0);
    step(1, 6, 4, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 6, 0, 0);
    drive(0, 0, 0, 1, 2, 0, 0);
    decide();
    settle();

    // Offer held under back-pressure while the offered task is suspended
    step(1, 5, 7, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 5, 0, 0);
    decide();
    next_ready = 1'b0;
    k = 0;
    while (!next_valid && k < 40) begin
      tick();
      k++;
    end
    chk("held_offer_seen", next_valid, 1);
    for (int i = 0; i < 40; i++) begin
      if (i == 10) drive(0, 0, 0, 0, 0, 1, 5);
      else tick();
    end
    chk("held_offer_valid", next_valid, 1);
    chk("held_offer_id", next_task_id, 5);
    next_ready = 1'b1;
    k = 0;
    while (sb_q.size() != 0 && k < 20) begin
      tick();
      k++;
    end
    next_ready = 1'b0;
    repeat (2) tick();
    decide();
    settle();
    drive(0, 0, 0, 0, 0, 1, 5);
    chk("suspend_cur_drops", cur_valid, 0);
    decide();
    settle();

    // Activate and suspend of the same ID in one cycle
    reset_dut();
    drive(0, 0, 0, 1, 4, 1, 4);
    repeat (2) tick();
    chk("same_id_idle", idle, 1);
    decide();
    settle();

    // Reset during SCAN
    drive(0, 0, 0, 1, 1, 0, 0);
    repeat (5) tick();
    reset_dut();
    next_ready = 1'b1;
    repeat (30) tick();
    chk("scan_rst_no_offer", next_valid, 0);

    // Reset during OFFER, with next_ready low so nothing transfers first
    next_ready = 1'b0;
    drive(0, 0, 0, 1, 1, 0, 0);
    k = 0;
    while (!next_valid && k < 40) begin
      tick();
      k++;
    end
    chk("offer_before_rst", next_valid, 1);
    reset_dut();
    next_ready = 1'b1;
    repeat (30) tick();
    chk("offer_rst_dropped", next_valid, 0);
    chk("offer_rst_count", switch_count, 0);
    next_ready = 1'b0;

    // Randomized events against the model
    reset_dut();
    for (int n = 0; n < 60; n++) begin
      id_a = $urandom_range(0, NT - 1);
      id_s = ($urandom_range(0, 3) == 0) ? id_a : $urandom_range(0, NT - 1);
      drive($urandom_range(0, 1), $urandom_range(0, NT - 1), $urandom_range(0, 15),
            $urandom_range(0, 9) < 7, id_a, $urandom_range(0, 9) < 4, id_s);
      if ($urandom_range(0, 3) == 0)
        drive(1, $urandom_range(0, NT - 1), $urandom_range(0, 15),
              1, $urandom_range(0, NT - 1), 0, 0);
      decide();
      settle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
